// File: rtl/update_sequencer.sv
// update_sequencer: buffers HPS edge-weight updates written over Avalon and
// feeds them one at a time to the arbitrage Container with a start/done
// handshake.
// Optional build macro: UPD_TIMEOUT_EN enables the WAIT watchdog
// (TIMEOUT_CYCLES) and the sticky timeout status bit.
module update_sequencer #(
    parameter int PRED_BITS      = 5,
    parameter int WEIGHT_BITS    = 32,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic                   read,
    input  logic [2:0]             address,
    input  logic [WEIGHT_BITS-1:0] writedata,
    output logic [WEIGHT_BITS-1:0] readdata,
    output logic [PRED_BITS-1:0]   upd_src,
    output logic [PRED_BITS-1:0]   upd_dst,
    output logic [WEIGHT_BITS-1:0] upd_e,
    output logic                   upd_start,
    input  logic                   upd_done,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time parameter sanity check
    if (TIMEOUT_CYCLES < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        WEIGHT_BITS < 2 * PRED_BITS || WEIGHT_BITS < 16) begin : g_param_check
        $error("update_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [PRED_BITS-1:0]   src;
        logic [PRED_BITS-1:0]   dst;
        logic [WEIGHT_BITS-1:0] e;
    } entry_t;

    state_t                 state;
    entry_t                 mem [DEPTH];
    logic [AW-1:0]          wptr, rptr;
    logic [CW-1:0]          count;
    logic [PRED_BITS-1:0]   stg_src, stg_dst;
    logic                   ovf_flag, to_flag;
    logic [WEIGHT_BITS-1:0] status;

    logic wr_en, do_stage, do_commit, flush, clr;
    logic full, empty, pop, push, drop, to_hit;

    assign wr_en     = chipselect && write;
    assign do_stage  = wr_en && (address == 3'd0);
    assign do_commit = wr_en && (address == 3'd1);
    assign flush     = wr_en && (address == 3'd3) && writedata[0];
    assign clr       = wr_en && (address == 3'd3) && writedata[1];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A flush empties the head too, so it also suppresses this cycle's pop.
    assign pop   = (state == IDLE) && !empty && !flush;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push  = do_commit && (!full || pop) && !flush;
    // A commit discarded by a flush is not an overflow.
    assign drop  = do_commit && full && !pop && !flush;

`ifdef UPD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Count cycles spent in WAIT; restarts on every entry from ISSUE
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == ISSUE)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + TW'(1);
    end

    // Limit hit this cycle; a coincident upd_done counts as completion
    assign to_hit = (state == WAIT) && !upd_done &&
                    (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Staged node indices, reused by every subsequent commit
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_src <= '0;
            stg_dst <= '0;
        end else if (do_stage) begin
            stg_src <= writedata[2*PRED_BITS-1:PRED_BITS];
            stg_dst <= writedata[PRED_BITS-1:0];
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{src: stg_src, dst: stg_dst, e: writedata};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Issue FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            upd_src   <= '0;
            upd_dst   <= '0;
            upd_e     <= '0;
            upd_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        upd_src   <= mem[rptr].src;
                        upd_dst   <= mem[rptr].dst;
                        upd_e     <= mem[rptr].e;
                        upd_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    upd_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (upd_done || to_hit) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    upd_start <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_flag <= 1'b0;
            to_flag  <= 1'b0;
        end else begin
            if (drop)     ovf_flag <= 1'b1;
            else if (clr) ovf_flag <= 1'b0;
            if (to_hit)   to_flag  <= 1'b1;
            else if (clr) to_flag  <= 1'b0;
        end
    end

    // Status word assembled from current-cycle state
    always_comb begin
        status       = '0;
        status[7:0]  = 8'(count);
        status[8]    = busy;
        status[9]    = ovf_flag;
        status[10]   = to_flag;
    end

    // Read port, latency 1; unmapped addresses return zero
    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (chipselect && read && (address == 3'd2))
            readdata <= status;
        else
            readdata <= '0;
    end

endmodule

// File: tb/tb_update_sequencer.sv
// Testbench for update_sequencer: randomized and directed Avalon traffic with
// a queue-based reference model; a monitor compares every upd_start, busy and
// readdata against expectations queued by the model.
module tb_update_sequencer;
    localparam int PB = 5;
    localparam int WB = 32;
    localparam int D  = 8;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [2:0]    address = '0;
    logic [WB-1:0] writedata = '0;
    logic [WB-1:0] readdata;
    logic [PB-1:0] upd_src, upd_dst;
    logic [WB-1:0] upd_e;
    logic          upd_start, busy;
    logic          upd_done = 1'b0;

    always #5 clk = ~clk;

    update_sequencer #(
        .PRED_BITS(PB), .WEIGHT_BITS(WB), .DEPTH(D), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .upd_src(upd_src), .upd_dst(upd_dst),
        .upd_e(upd_e), .upd_start(upd_start), .upd_done(upd_done), .busy(busy)
    );

    typedef struct {
        logic [PB-1:0] s;
        logic [PB-1:0] d;
        logic [WB-1:0] e;
    } upd_t;
    typedef struct { upd_t u; int cyc; } exp_t;
    typedef struct { logic [WB-1:0] v; int cyc; } rd_t;

    upd_t m_q[$];
    exp_t exp_q[$];
    rd_t  rd_q[$];

    int            cyc = 0;
    bit            m_inflight = 0;
    int            m_start = 0;
    bit            m_ovf = 0, m_to = 0;
    logic [PB-1:0] m_ss = '0, m_sd = '0;
    bit            exp_busy = 0;
    int            n_tests = 0, n_fail = 0, n_starts = 0;
    int            done_mode = 0;  // 0 stall, 1 random, 2 forced high

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference model: one call per clock edge, working on the queue of
    // pending updates and a single "in flight" slot.
    task automatic model_step();
        bit            wr, commit, flush, clr, pop, to_now;
        logic [WB-1:0] st;
        upd_t          u;
        if (reset) begin
            m_q.delete();
            m_inflight = 0; m_ovf = 0; m_to = 0;
            m_ss = '0; m_sd = '0; exp_busy = 0;
            return;
        end
        wr     = chipselect && write;
        commit = wr && address == 3'd1;
        flush  = wr && address == 3'd3 && writedata[0];
        clr    = wr && address == 3'd3 && writedata[1];
        to_now = 0;
        if (chipselect && read) begin
            st = '0;
            if (address == 3'd2) begin
                st[7:0] = 8'(m_q.size());
                st[8]   = m_inflight;
                st[9]   = m_ovf;
                st[10]  = m_to;
            end
            rd_q.push_back('{st, cyc + 1});
        end
        pop = !m_inflight && m_q.size() > 0 && !flush;
        // The start cycle itself cannot complete; only later cycles can.
        if (m_inflight && cyc > m_start) begin
            if (upd_done) m_inflight = 0;
`ifdef UPD_TIMEOUT_EN
            else if (cyc - m_start == T) begin
                m_inflight = 0;
                to_now = 1;
            end
`endif
        end
        if (clr) begin m_ovf = 0; m_to = 0; end
        if (to_now) m_to = 1;
        if (pop) begin
            u = m_q.pop_front();
            exp_q.push_back('{u, cyc + 1});
            m_inflight = 1;
            m_start = cyc + 1;
        end
        if (commit && !flush) begin
            if (m_q.size() < D) m_q.push_back('{m_ss, m_sd, writedata});
            else m_ovf = 1;
        end
        if (flush) m_q.delete();
        if (wr && address == 3'd0) begin
            m_ss = writedata[2*PB-1:PB];
            m_sd = writedata[PB-1:0];
        end
        exp_busy = m_inflight;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        cyc++;
    end

    // Monitor: compares DUT outputs against what the model queued
    initial forever begin
        exp_t e;
        rd_t  r;
        @(negedge clk);
        if (upd_start === 1'b1) begin
            n_starts++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                check("unexpected_start", 64'(upd_start), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("upd_src", 64'(upd_src), 64'(e.u.s));
                check("upd_dst", 64'(upd_dst), 64'(e.u.d));
                check("upd_e",   64'(upd_e),   64'(e.u.e));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_start", 64'(upd_start), 64'(1));
        end
        check("busy", 64'(busy), 64'(exp_busy));
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            r = rd_q.pop_front();
            check("readdata", 64'(readdata), 64'(r.v));
        end
    end

    task automatic drive(input bit cs, input bit wr, input bit rd,
                         input logic [2:0] a, input logic [WB-1:0] d);
        @(posedge clk); #1;
        chipselect = cs; write = wr; read = rd; address = a; writedata = d;
        case (done_mode)
            1:       upd_done = ($urandom_range(0, 2) == 0);
            2:       upd_done = 1'b1;
            default: upd_done = 1'b0;
        endcase
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [WB-1:0] d);
        drive(1, 1, 0, a, d);
    endtask
    task automatic rd_reg(input logic [2:0] a);
        drive(1, 0, 1, a, '0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 3'd0, '0);
    endtask
    task automatic pulse_done();
        done_mode = 2; idle(1); done_mode = 0;
    endtask
    task automatic drain();
        done_mode = 1;
        for (int i = 0; i < 3000 && (m_q.size() > 0 || m_inflight); i++) idle(1);
        done_mode = 0;
        idle(3);
    endtask

    initial begin
        int s0;
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_upd_src",   64'(upd_src),   64'(0));
        check("rst_upd_dst",   64'(upd_dst),   64'(0));
        check("rst_upd_e",     64'(upd_e),     64'(0));
        check("rst_upd_start", 64'(upd_start), 64'(0));
        check("rst_readdata",  64'(readdata),  64'(0));
        rd_reg(3'd2);
        rd_reg(3'd5);

        // Single update: src=9, dst=3, weight 0x1000
        done_mode = 0;
        wr_reg(3'd0, 32'h0000_0123);
        s0 = n_starts;
        wr_reg(3'd1, 32'h0000_1000);
        idle(2);
        @(negedge clk);
        check("single_start_count", 64'(n_starts - s0), 64'(1));
        check("single_src", 64'(upd_src), 64'(9));
        check("single_dst", 64'(upd_dst), 64'(3));
        check("single_e",   64'(upd_e),   64'(32'h1000));
        idle(4);
        pulse_done();
        idle(3);

        // Ordering under a stalled Container
        s0 = n_starts;
        wr_reg(3'd1, 32'd1); wr_reg(3'd1, 32'd2); wr_reg(3'd1, 32'd3);
        idle(4);
        rd_reg(3'd2);
        drain();
        check("order_starts", 64'(n_starts - s0), 64'(3));

        // Overflow: DEPTH+2 commits with the Container stalled
        s0 = n_starts;
        for (int i = 0; i < D + 2; i++) wr_reg(3'd1, 32'(100 + i));
        idle(2);
        rd_reg(3'd2);
        drain();
        check("ovf_starts", 64'(n_starts - s0), 64'(D + 1));

        // Full FIFO with a pop in the commit cycle
        wr_reg(3'd3, 32'h2);
        for (int i = 0; i < D + 1; i++) wr_reg(3'd1, 32'(200 + i));
        idle(3);
        rd_reg(3'd2);
        pulse_done();
        wr_reg(3'd1, 32'd300);
        rd_reg(3'd2);
        drain();

        // Flush with one in flight and four queued
        wr_reg(3'd0, 32'h0000_0085);
        for (int i = 0; i < 5; i++) wr_reg(3'd1, 32'(400 + i));
        idle(3);
        wr_reg(3'd3, 32'h1);
        rd_reg(3'd2);
        @(negedge clk);
        check("flush_inflight_e", 64'(upd_e), 64'(400));
        s0 = n_starts;
        drain();
        check("flush_no_starts", 64'(n_starts - s0), 64'(0));

`ifdef UPD_TIMEOUT_EN
        // Watchdog: never complete, both updates time out in turn
        wr_reg(3'd3, 32'h2);
        s0 = n_starts;
        wr_reg(3'd1, 32'd500); wr_reg(3'd1, 32'd501);
        idle(45);
        rd_reg(3'd2);
        check("timeout_starts", 64'(n_starts - s0), 64'(2));
        drain();
`endif

        // Reset while waiting drops everything
        for (int i = 0; i < 3; i++) wr_reg(3'd1, 32'(600 + i));
        idle(3);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        s0 = n_starts;
        rd_reg(3'd2);
        idle(5);
        check("reset_no_starts", 64'(n_starts - s0), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) done_mode = ($urandom_range(0, 2) == 0) ? 0 : 1;
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    wr_reg(3'd0, $urandom);
                2, 3, 4: wr_reg(3'd1, $urandom);
                5, 6:    rd_reg(3'($urandom_range(0, 7)));
                7:       wr_reg(3'd3, {30'($urandom), 1'($urandom_range(0, 2) == 0),
                                       1'($urandom_range(0, 9) == 0)});
                8:       wr_reg(3'($urandom_range(4, 7)), $urandom);
                9:       drive(0, 1, 1, 3'($urandom_range(0, 3)), $urandom);
                default: idle(1);
            endcase
        end
        drain();
        rd_reg(3'd2);
        idle(3);
        check("pending_starts", 64'(exp_q.size()), 64'(0));
        check("pending_reads",  64'(rd_q.size()),  64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
